// File: rtl/speed_meter_pkg.sv
// ---------------------------------------------------------------------------
// speed_meter_pkg
// Shared definitions for the speed/period meter:
//   - state_t          : controller FSM states (IDLE, REQ, WAIT_ACK, BUSY)
//   - DEF_RPM_K        : default divider dividend (50 MHz * 60 / 7 pole pairs)
//   - DEF_PERIOD_MAX   : default stall threshold in clk cycles (0.5 s @ 50 MHz)
//   - DEF_ACK_TIMEOUT  : default cycles to wait for the divider to acknowledge
//   - SYNC_STAGES      : depth of the zero-crossing input synchronizer
// ---------------------------------------------------------------------------
package speed_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_BUSY     = 2'd3
    } state_t;

    localparam logic [31:0] DEF_RPM_K       = 32'd428_571_428;
    localparam logic [31:0] DEF_PERIOD_MAX  = 32'd25_000_000;
    localparam int          DEF_ACK_TIMEOUT = 8;
    localparam int          SYNC_STAGES     = 2;

endpackage

// File: rtl/speed_period_meter_period_averager.sv
// ---------------------------------------------------------------------------
// period_averager
// Moving average over the last four valid periods. While the history is
// refilling the average covers the samples available: 1 -> the sample,
// 2 -> sum >> 1, 3 -> mean of the two newest, 4 -> sum >> 2.
// o_avg_next is combinational and already includes i_sample, so the caller
// can register it in the same cycle it pushes.
// The module only exists when PERIOD_AVG_EN is defined.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_clear      : empty the history (first edge, stall, enable low)
//   i_push       : shift i_sample into the history
//   i_sample     : newest raw period
//   o_avg_next   : average including i_sample
// ---------------------------------------------------------------------------
`ifdef PERIOD_AVG_EN
module period_averager
    import speed_meter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [31:0] i_sample,
    output logic [31:0] o_avg_next
);

    logic [31:0] r_samp [4];
    logic [33:0] r_sum;
    logic [2:0]  r_cnt;

    logic [33:0] w_sum_next;
    logic [32:0] w_pair;
    logic [2:0]  w_cnt_next;

    // Running sum: add the newcomer, drop the oldest once the window is full.
    assign w_sum_next = r_sum + {2'b00, i_sample}
                      - ((r_cnt == 3'd4) ? {2'b00, r_samp[3]} : 34'd0);
    assign w_pair     = {1'b0, i_sample} + {1'b0, r_samp[0]};
    assign w_cnt_next = (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;

    always_comb begin
        case (w_cnt_next)
            3'd1:    o_avg_next = i_sample;
            3'd2:    o_avg_next = w_sum_next[32:1];
            // Three samples cannot be divided by a shift; use the two newest.
            3'd3:    o_avg_next = w_pair[32:1];
            default: o_avg_next = w_sum_next[33:2];
        endcase
    end

    // NOTE: the sample registers are reset like ordinary flops (not left as
    // uninitialised memory) so the running sum always matches the history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_samp[i] <= '0;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < 4; i++) r_samp[i] <= '0;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_samp[0] <= i_sample;
            r_samp[1] <= r_samp[0];
            r_samp[2] <= r_samp[1];
            r_samp[3] <= r_samp[2];
            r_sum     <= w_sum_next;
            r_cnt     <= w_cnt_next;
        end
    end

endmodule
`endif

// File: rtl/speed_period_meter.sv
// ---------------------------------------------------------------------------
// speed_period_meter
// Measures the period between rising zero-crossing edges, requests
// RPM_K / period from an external 32-bit divider and publishes the quotient
// as rpm. A period that reaches PERIOD_MAX declares a stall (rpm = 0).
// Optional feature: define PERIOD_AVG_EN to feed the divider a 4-sample
// moving average of the period instead of the raw period.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   enable            : measurement enable; low clears measurement state
//   zc_in             : raw zero-crossing comparator (asynchronous)
//   division_active   : divider busy flag
//   quotient          : divider result
//   start_division    : one-cycle divide request
//   dividend/divisor  : divider operands, stable from request to completion
//   rpm / rpm_valid   : speed result and its one-cycle update strobe
//   period            : last raw period in clk cycles
//   stalled           : no edge within PERIOD_MAX
//   div_error         : sticky, divider failed to acknowledge a request
// ---------------------------------------------------------------------------
module speed_period_meter
    import speed_meter_pkg::*;
#(
    parameter logic [31:0] RPM_K       = DEF_RPM_K,
    parameter logic [31:0] PERIOD_MAX  = DEF_PERIOD_MAX,
    parameter int          ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        zc_in,
    input  logic        division_active,
    input  logic [31:0] quotient,
    output logic        start_division,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    output logic [31:0] rpm,
    output logic        rpm_valid,
    output logic [31:0] period,
    output logic        stalled,
    output logic        div_error
);

    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

    // Input conditioning
    logic [SYNC_STAGES-1:0] r_zc_sync;
    logic                   r_zc_prev;
    logic                   r_edge;

    // Measurement state
    logic [31:0] r_count;
    logic        r_first;
    logic [31:0] r_period;
    logic        r_stalled;
    logic [31:0] r_pend;
    logic        r_pend_valid;
    logic [31:0] w_avg;
    logic        w_stall_evt;

    // Divider handshake
    state_t      r_state;
    state_t      w_state_next;
    logic        w_load;
    logic        w_done;
    logic        w_timeout;
    logic [7:0]  r_ack_cnt;
    logic        r_discard;
    logic [31:0] r_divisor;
    logic [31:0] r_rpm;
    logic        r_rpm_valid;
    logic        r_div_error;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zc_sync <= '0;
            r_zc_prev <= 1'b0;
            r_edge    <= 1'b0;
        end else begin
            r_zc_sync <= {r_zc_sync[SYNC_STAGES-2:0], zc_in};
            r_zc_prev <= r_zc_sync[SYNC_STAGES-1];
            // Registered edge pulse: three cycles from pin to pulse.
            r_edge    <= r_zc_sync[SYNC_STAGES-1] & ~r_zc_prev;
        end
    end

    // Counter is about to reach PERIOD_MAX with no edge to rescue it; an edge
    // in the same cycle wins.
    assign w_stall_evt = enable && !r_edge && (r_count == PERIOD_MAX - 32'd1);

`ifdef PERIOD_AVG_EN
    logic w_avg_clear;
    logic w_avg_push;

    assign w_avg_clear = !enable || w_stall_evt || (r_edge && r_first);
    assign w_avg_push  = enable && r_edge && !r_first;

    period_averager u_avg (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_avg_clear),
        .i_push     (w_avg_push),
        .i_sample   (r_count),
        .o_avg_next (w_avg)
    );
`else
    assign w_avg = r_count;
`endif

    // Controller FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next   = r_state;
        start_division = 1'b0;
        w_load         = 1'b0;
        w_done         = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_valid && !r_stalled) begin
                    w_load       = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                start_division = 1'b1;
                w_state_next   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (division_active) begin
                    w_state_next = ST_BUSY;
                end else if (r_ack_cnt == ACK_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!division_active) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Measurement and result datapath. Later assignments in this block take
    // priority: edge/stall/enable handling overrides the FSM bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_first      <= 1'b1;
            r_period     <= '0;
            r_stalled    <= 1'b1;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_ack_cnt    <= '0;
            r_discard    <= 1'b0;
            r_divisor    <= '0;
            r_rpm        <= '0;
            r_rpm_valid  <= 1'b0;
            r_div_error  <= 1'b0;
        end else begin
            r_rpm_valid <= 1'b0;

            if (!enable)                  r_count <= '0;
            else if (r_edge)              r_count <= 32'd1;
            else if (r_count != PERIOD_MAX) r_count <= r_count + 32'd1;

            if (r_state == ST_WAIT_ACK) r_ack_cnt <= r_ack_cnt + 8'd1;
            else                        r_ack_cnt <= '0;

            if (w_load) begin
                r_divisor    <= r_pend;
                r_pend_valid <= 1'b0;
                r_discard    <= 1'b0;
            end

            if (w_timeout) r_div_error <= 1'b1;

            if (w_done && !r_discard && enable) begin
                r_rpm       <= quotient;
                r_rpm_valid <= 1'b1;
            end

            if (!enable) begin
                // rpm is intentionally kept; an in-flight result is dropped.
                r_first      <= 1'b1;
                r_stalled    <= 1'b1;
                r_pend_valid <= 1'b0;
                r_discard    <= 1'b1;
            end else if (r_edge) begin
                if (r_first) begin
                    r_first <= 1'b0;
                end else begin
                    r_period     <= r_count;
                    r_stalled    <= 1'b0;
                    r_pend       <= w_avg;
                    r_pend_valid <= 1'b1;
                end
            end else if (w_stall_evt) begin
                r_stalled    <= 1'b1;
                r_first      <= 1'b1;
                r_pend_valid <= 1'b0;
                r_discard    <= 1'b1;
                r_rpm        <= '0;
                // Strobe only if this actually changes what downstream sees.
                if (!r_stalled || r_rpm != 32'd0) r_rpm_valid <= 1'b1;
            end
        end
    end

    assign dividend  = RPM_K;
    assign divisor   = r_divisor;
    assign rpm       = r_rpm;
    assign rpm_valid = r_rpm_valid;
    assign period    = r_period;
    assign stalled   = r_stalled;
    assign div_error = r_div_error;

endmodule

// File: tb/tb_speed_period_meter.sv
// ---------------------------------------------------------------------------
// tb_speed_period_meter
// Directed bench for speed_period_meter with RPM_K = 1000, PERIOD_MAX = 500,
// ACK_TIMEOUT = 8 and a behavioural divider with programmable latency.
// ---------------------------------------------------------------------------
module tb_speed_period_meter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        zc_in;
    logic        division_active;
    logic [31:0] quotient;
    logic        start_division;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] rpm;
    logic        rpm_valid;
    logic [31:0] period;
    logic        stalled;
    logic        div_error;

    int tests_run    = 0;
    int tests_failed = 0;

    // Divider model controls and activity monitor
    bit          ack_en  = 1'b1;
    int          div_lat = 10;
    int          n_start = 0;
    int          n_rv    = 0;
    logic [31:0] last_rv_rpm = '0;
    logic [31:0] div_log [$];

    speed_period_meter #(
        .RPM_K       (32'd1000),
        .PERIOD_MAX  (32'd500),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .zc_in           (zc_in),
        .division_active (division_active),
        .quotient        (quotient),
        .start_division  (start_division),
        .dividend        (dividend),
        .divisor         (divisor),
        .rpm             (rpm),
        .rpm_valid       (rpm_valid),
        .period          (period),
        .stalled         (stalled),
        .div_error       (div_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider: acknowledges a request, stays busy div_lat cycles, then
    // presents dividend / divisor as it was captured at the request.
    initial begin
        logic [31:0] lat_dividend;
        logic [31:0] lat_divisor;
        division_active = 1'b0;
        quotient        = '0;
        forever begin
            @(negedge clk);
            if (!reset && ack_en && start_division) begin
                lat_dividend    = dividend;
                lat_divisor     = divisor;
                division_active = 1'b1;
                for (int i = 0; i < div_lat && !reset; i++) @(negedge clk);
                quotient        = (lat_divisor == 0) ? '1 : lat_dividend / lat_divisor;
                division_active = 1'b0;
            end
            if (reset) division_active = 1'b0;
        end
    end

    // Monitor sampled on the falling edge, away from register updates.
    initial begin
        forever begin
            @(negedge clk);
            if (start_division) begin
                n_start++;
                div_log.push_back(divisor);
            end
            if (rpm_valid) begin
                n_rv++;
                last_rv_rpm = rpm;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rising edge on zc_in now, next rising edge gap cycles later.
    task automatic pulse_gap(input int gap);
        zc_in = 1'b1;
        cycles(2);
        zc_in = 1'b0;
        cycles(gap - 2);
    endtask

    // Raise zc_in and wait (bounded) for the divider to go busy.
    task automatic edge_until_busy(input string tag);
        bit seen;
        seen  = 1'b0;
        zc_in = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycles(1);
            if (division_active) seen = 1'b1;
        end
        zc_in = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_busy_wait: division_active never rose within 30 cycles", tag);
        end
    endtask

    task automatic expect_reset_values(input string tag);
        tests_run++;
        if (start_division !== 1'b0) begin tests_failed++; $display("FAIL %s_start: got %b expected 0", tag, start_division); end
        tests_run++;
        if (dividend !== 32'd1000) begin tests_failed++; $display("FAIL %s_dividend: got %0d expected 1000", tag, dividend); end
        tests_run++;
        if (divisor !== 32'd0) begin tests_failed++; $display("FAIL %s_divisor: got %0d expected 0", tag, divisor); end
        tests_run++;
        if (rpm !== 32'd0) begin tests_failed++; $display("FAIL %s_rpm: got %0d expected 0", tag, rpm); end
        tests_run++;
        if (rpm_valid !== 1'b0) begin tests_failed++; $display("FAIL %s_rpm_valid: got %b expected 0", tag, rpm_valid); end
        tests_run++;
        if (period !== 32'd0) begin tests_failed++; $display("FAIL %s_period: got %0d expected 0", tag, period); end
        tests_run++;
        if (stalled !== 1'b1) begin tests_failed++; $display("FAIL %s_stalled: got %b expected 1", tag, stalled); end
        tests_run++;
        if (div_error !== 1'b0) begin tests_failed++; $display("FAIL %s_div_error: got %b expected 0", tag, div_error); end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        zc_in  = 1'b0;
        cycles(3);
        expect_reset_values("reset");
        reset = 1'b0;
        cycles(2);
    endtask

    // Steady spin: period 100 -> divisor 100, rpm 1000/100 = 10.
    task automatic test_steady();
        int s0;
        int r0;
        div_lat = 10;
        ack_en  = 1'b1;
        enable  = 1'b1;
        cycles(2);
        s0 = n_start;
        r0 = n_rv;
        div_log.delete();
        repeat (5) pulse_gap(100);
        tests_run++;
        if (n_start - s0 != 4) begin tests_failed++; $display("FAIL steady_requests: got %0d expected 4", n_start - s0); end
        tests_run++;
        if (n_rv - r0 != 4) begin tests_failed++; $display("FAIL steady_rpm_valid: got %0d expected 4", n_rv - r0); end
        foreach (div_log[i]) begin
            tests_run++;
            if (div_log[i] !== 32'd100) begin tests_failed++; $display("FAIL steady_divisor[%0d]: got %0d expected 100", i, div_log[i]); end
        end
        tests_run++;
        if (rpm !== 32'd10) begin tests_failed++; $display("FAIL steady_rpm: got %0d expected 10", rpm); end
        tests_run++;
        if (period !== 32'd100) begin tests_failed++; $display("FAIL steady_period: got %0d expected 100", period); end
        tests_run++;
        if (stalled !== 1'b0) begin tests_failed++; $display("FAIL steady_stalled: got %b expected 0", stalled); end
    endtask

    // No edges for > PERIOD_MAX: stall, rpm 0 with one strobe; the next lone
    // edge only restarts the counter.
    task automatic test_stall();
        int s0;
        int r0;
        s0 = n_start;
        r0 = n_rv;
        cycles(450);
        tests_run++;
        if (stalled !== 1'b1) begin tests_failed++; $display("FAIL stall_flag: got %b expected 1", stalled); end
        tests_run++;
        if (rpm !== 32'd0) begin tests_failed++; $display("FAIL stall_rpm: got %0d expected 0", rpm); end
        tests_run++;
        if (n_rv - r0 != 1) begin tests_failed++; $display("FAIL stall_rpm_valid_pulses: got %0d expected 1", n_rv - r0); end
        tests_run++;
        if (last_rv_rpm !== 32'd0) begin tests_failed++; $display("FAIL stall_strobed_rpm: got %0d expected 0", last_rv_rpm); end
        pulse_gap(60);
        tests_run++;
        if (n_start != s0) begin tests_failed++; $display("FAIL stall_first_edge_request: got %0d requests expected 0", n_start - s0); end
        tests_run++;
        if (stalled !== 1'b1) begin tests_failed++; $display("FAIL stall_after_first_edge: got %b expected 1", stalled); end
    endtask

    // Two edges 40 cycles apart while the divider is busy: only the newest
    // period (40) is requested after the 100-cycle result.
    task automatic test_back_to_back();
        int s0;
        int r0;
        enable = 1'b0;
        cycles(5);
        enable  = 1'b1;
        div_lat = 60;
        s0 = n_start;
        r0 = n_rv;
        div_log.delete();
        pulse_gap(100);
        pulse_gap(10);
        pulse_gap(40);
        pulse_gap(150);
        tests_run++;
        if (n_start - s0 != 2) begin tests_failed++; $display("FAIL b2b_requests: got %0d expected 2", n_start - s0); end
        tests_run++;
        if (div_log.size() != 2) begin
            tests_failed++; $display("FAIL b2b_log_size: got %0d expected 2", div_log.size());
        end else begin
            tests_run++;
            if (div_log[0] !== 32'd100) begin tests_failed++; $display("FAIL b2b_divisor0: got %0d expected 100", div_log[0]); end
            tests_run++;
            if (div_log[1] !== 32'd40) begin tests_failed++; $display("FAIL b2b_divisor1: got %0d expected 40", div_log[1]); end
        end
        tests_run++;
        if (n_rv - r0 != 2) begin tests_failed++; $display("FAIL b2b_rpm_valid: got %0d expected 2", n_rv - r0); end
        tests_run++;
        if (rpm !== 32'd25) begin tests_failed++; $display("FAIL b2b_rpm: got %0d expected 25", rpm); end
        tests_run++;
        if (period !== 32'd40) begin tests_failed++; $display("FAIL b2b_period: got %0d expected 40", period); end
    endtask

    // Divider never acknowledges: div_error sets, next edge retries.
    task automatic test_timeout();
        int s0;
        int r0;
        s0      = n_start;
        r0      = n_rv;
        ack_en  = 1'b0;
        div_lat = 10;
        pulse_gap(100);
        tests_run++;
        if (div_error !== 1'b1) begin tests_failed++; $display("FAIL timeout_div_error: got %b expected 1", div_error); end
        tests_run++;
        if (n_start - s0 != 1) begin tests_failed++; $display("FAIL timeout_requests: got %0d expected 1", n_start - s0); end
        tests_run++;
        if (n_rv != r0) begin tests_failed++; $display("FAIL timeout_rpm_valid: got %0d expected 0", n_rv - r0); end
        ack_en = 1'b1;
        pulse_gap(50);
        tests_run++;
        if (n_start - s0 != 2) begin tests_failed++; $display("FAIL timeout_retry_requests: got %0d expected 2", n_start - s0); end
        tests_run++;
        if (rpm !== 32'd10) begin tests_failed++; $display("FAIL timeout_retry_rpm: got %0d expected 10", rpm); end
        tests_run++;
        if (div_error !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky: got %b expected 1", div_error); end
    endtask

    // enable dropped mid-division: result discarded, rpm kept, stalled set.
    task automatic test_enable();
        int r0;
        div_lat = 30;
        r0 = n_rv;
        edge_until_busy("enable");
        enable = 1'b0;
        cycles(50);
        tests_run++;
        if (n_rv != r0) begin tests_failed++; $display("FAIL enable_discard_pulses: got %0d expected 0", n_rv - r0); end
        tests_run++;
        if (rpm !== 32'd10) begin tests_failed++; $display("FAIL enable_rpm_kept: got %0d expected 10", rpm); end
        tests_run++;
        if (stalled !== 1'b1) begin tests_failed++; $display("FAIL enable_stalled: got %b expected 1", stalled); end
    endtask

    // Periods 100, 100, 200, 200 from a fresh start.
    task automatic test_average();
        logic [31:0] exp_div [4];
        logic [31:0] exp_rpm;
        enable  = 1'b1;
        div_lat = 10;
`ifdef PERIOD_AVG_EN
        exp_div[0] = 32'd100; exp_div[1] = 32'd100; exp_div[2] = 32'd150; exp_div[3] = 32'd150;
        exp_rpm    = 32'd6;
`else
        exp_div[0] = 32'd100; exp_div[1] = 32'd100; exp_div[2] = 32'd200; exp_div[3] = 32'd200;
        exp_rpm    = 32'd5;
`endif
        div_log.delete();
        pulse_gap(100);
        pulse_gap(100);
        pulse_gap(200);
        pulse_gap(200);
        pulse_gap(60);
        tests_run++;
        if (div_log.size() != 4) begin
            tests_failed++; $display("FAIL avg_log_size: got %0d expected 4", div_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (div_log[i] !== exp_div[i]) begin tests_failed++; $display("FAIL avg_divisor[%0d]: got %0d expected %0d", i, div_log[i], exp_div[i]); end
            end
        end
        tests_run++;
        if (rpm !== exp_rpm) begin tests_failed++; $display("FAIL avg_rpm: got %0d expected %0d", rpm, exp_rpm); end
        tests_run++;
        if (stalled !== 1'b0) begin tests_failed++; $display("FAIL avg_stalled: got %b expected 0", stalled); end
    endtask

    // Asynchronous reset while the divider is busy.
    task automatic test_reset_mid_busy();
        div_lat = 60;
        edge_until_busy("rst_busy");
        cycles(5);
        #2;
        reset = 1'b1;
        #1;
        expect_reset_values("rst_busy");
        cycles(3);
        reset = 1'b0;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_steady();
        test_stall();
        test_back_to_back();
        test_timeout();
        test_enable();
        test_average();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
